// File: rtl/systolic_operand_skewer.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_operand_skewer
//  Description : Upstream feeder of the systolic processor. Takes one k-slice
//                per beat (column k of A and row k of B). Drives the array with
//                diagonally skewed lane vectors, where lane q is delayed q
//                extra cycles. Idle cycles shift in zero bubbles. An
//                accumulator clear goes out with the first beat of every
//                matrix. A done pulse goes out when the last element leaves
//                the final lane. Input is held off while the array drains.
//
//  Ports       : i_clock   - single clock, rising edge
//                i_reset   - asynchronous, active-high reset
//                i_valid   - input beat present
//                i_last    - qualifies i_valid: final k-slice of the matrix
//                i_a_col   - A[:,k], lane q = bits [q*I_BITS +: I_BITS]
//                i_b_row   - B[k,:], same lane packing
//                o_ready   - beat accepted when i_valid & o_ready
//                o_a_full  - skewed A lanes to the array
//                o_b_full  - skewed B lanes to the array
//                o_valid   - some output lane carries a real (non-bubble) element
//                o_clear   - one-cycle accumulator clear, aligned with lane 0
//                o_done    - one-cycle pulse: last element left lane SIZE-1
//
//  Revision    : 1.0 - initial release
// ============================================================================
module systolic_operand_skewer #(
    parameter int SIZE   = 32,
    parameter int I_BITS = 8,
    parameter int DRAIN  = 2 * SIZE
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_valid,
    input  logic                     i_last,
    input  logic [SIZE*I_BITS-1:0]   i_a_col,
    input  logic [SIZE*I_BITS-1:0]   i_b_row,
    output logic                     o_ready,
    output logic [SIZE*I_BITS-1:0]   o_a_full,
    output logic [SIZE*I_BITS-1:0]   o_b_full,
    output logic                     o_valid,
    output logic                     o_clear,
    output logic                     o_done
);

    // DRAIN-1 is the largest value ever loaded, so clog2(DRAIN) bits suffice.
    localparam int c_CNT_W = (DRAIN > 1) ? $clog2(DRAIN) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FLUSH  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nx;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 w_accept;
    logic [SIZE-1:0]      r_tag;       // accept flag, bit j aligned with lane j output
    logic [SIZE-1:0]      r_last_tag;  // last-beat flag, same alignment
    logic                 r_clear;

    // Ready is a pure function of state. It therefore reads 1 as soon as reset asserts.
    assign o_ready  = (r_state != S_FLUSH);
    assign w_accept = i_valid & o_ready;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nx = i_last ? S_FLUSH : S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_accept && i_last) begin
                    w_state_nx = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (r_cnt == '0) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // The drain counter is loaded with DRAIN-1 on entry to FLUSH. FLUSH then
    // lasts exactly DRAIN cycles, counting down through zero.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if ((r_state != S_FLUSH) && (w_state_nx == S_FLUSH)) begin
            r_cnt <= c_CNT_W'(DRAIN - 1);
        end else if ((r_state == S_FLUSH) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - c_CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Tag, last-flag and clear registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_tag      <= '0;
            r_last_tag <= '0;
            r_clear    <= 1'b0;
        end else begin
            r_tag      <= (r_tag << 1) | SIZE'(w_accept);
            r_last_tag <= (r_last_tag << 1) | SIZE'(w_accept & i_last);
            // Only the opening beat of a matrix is accepted while in IDLE.
            r_clear    <= w_accept && (r_state == S_IDLE);
        end
    end

    assign o_valid = |r_tag;
    assign o_done  = r_last_tag[SIZE-1];
    assign o_clear = r_clear;

    // ------------------------------------------------------------------
    // Skew lanes: lane q is a (q+1)-deep shift register per operand. The
    // lanes shift every cycle, and zeros enter whenever no beat is accepted.
    // ------------------------------------------------------------------
    generate
        for (genvar q = 0; q < SIZE; q++) begin : g_lane
            logic [I_BITS-1:0] r_sa [0:q];
            logic [I_BITS-1:0] r_sb [0:q];

            always_ff @(posedge i_clock or posedge i_reset) begin
                if (i_reset) begin
                    for (int s = 0; s <= q; s++) begin
                        r_sa[s] <= '0;
                        r_sb[s] <= '0;
                    end
                end else begin
                    r_sa[0] <= w_accept ? i_a_col[q*I_BITS +: I_BITS] : '0;
                    r_sb[0] <= w_accept ? i_b_row[q*I_BITS +: I_BITS] : '0;
                    for (int s = 1; s <= q; s++) begin
                        r_sa[s] <= r_sa[s-1];
                        r_sb[s] <= r_sb[s-1];
                    end
                end
            end

            assign o_a_full[q*I_BITS +: I_BITS] = r_sa[q];
            assign o_b_full[q*I_BITS +: I_BITS] = r_sb[q];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_systolic_operand_skewer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_systolic_operand_skewer
//  Description : Self-checking bench for systolic_operand_skewer with SIZE=4,
//                I_BITS=8, DRAIN=8. Every driven cycle pushes an expected
//                record into a history queue. Lane q output at cycle c is the
//                record pushed at cycle c-q-1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_operand_skewer;

    localparam int c_SIZE  = 4;
    localparam int c_IB    = 8;
    localparam int c_DRAIN = 8;
    localparam int c_W     = c_SIZE * c_IB;

    logic             i_clock;
    logic             i_reset;
    logic             i_valid;
    logic             i_last;
    logic [c_W-1:0]   i_a_col;
    logic [c_W-1:0]   i_b_row;
    logic             o_ready;
    logic [c_W-1:0]   o_a_full;
    logic [c_W-1:0]   o_b_full;
    logic             o_valid;
    logic             o_clear;
    logic             o_done;

    systolic_operand_skewer #(
        .SIZE   (c_SIZE),
        .I_BITS (c_IB),
        .DRAIN  (c_DRAIN)
    ) u_dut (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_valid  (i_valid),
        .i_last   (i_last),
        .i_a_col  (i_a_col),
        .i_b_row  (i_b_row),
        .o_ready  (o_ready),
        .o_a_full (o_a_full),
        .o_b_full (o_b_full),
        .o_valid  (o_valid),
        .o_clear  (o_clear),
        .o_done   (o_done)
    );

    initial begin
        i_clock = 1'b0;
        forever #5 i_clock = ~i_clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic           acc;
        logic           last;
        logic           first;
        logic [c_W-1:0] a;
        logic [c_W-1:0] b;
    } rec_t;

    rec_t hist[$];
    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    int   last_cyc  = -1000;
    bit   in_matrix = 1'b0;
    int   t0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [c_W-1:0] mk(input int k, input int base);
        logic [c_W-1:0] v;
        for (int q = 0; q < c_SIZE; q++) v[q*c_IB +: c_IB] = 8'(base + 16*k + q);
        return v;
    endfunction

    function automatic logic [7:0] ln(input logic [c_W-1:0] v, input int q);
        return v[q*c_IB +: c_IB];
    endfunction

    task automatic model_reset();
        rec_t z;
        z = '0;
        hist.delete();
        for (int i = 0; i < c_SIZE; i++) hist.push_back(z);
        last_cyc  = -1000;
        in_matrix = 1'b0;
    endtask

    // Compare the outputs of the current cycle. Then drive this cycle's inputs
    // and record what they must produce. Finally advance to #1 past the next edge.
    task automatic step(input bit v, input bit l, input logic [c_W-1:0] a, input logic [c_W-1:0] b);
        logic [c_W-1:0] ea, eb;
        bit ev, ec, ed, er, acc;
        rec_t r, n;
        ea = '0; eb = '0; ev = 0; ec = 0; ed = 0;
        for (int q = 0; q < c_SIZE; q++) begin
            r = hist[c_SIZE-1-q];
            ea[q*c_IB +: c_IB] = r.a[q*c_IB +: c_IB];
            eb[q*c_IB +: c_IB] = r.b[q*c_IB +: c_IB];
            ev = ev | r.acc;
            if (q == 0)        ec = r.first;
            if (q == c_SIZE-1) ed = r.last;
        end
        void'(hist.pop_front());
        er = !((cyc > last_cyc) && (cyc <= last_cyc + c_DRAIN));
        chk("a_full", 64'(o_a_full), 64'(ea));
        chk("b_full", 64'(o_b_full), 64'(eb));
        chk("valid",  64'(o_valid),  64'(ev));
        chk("clear",  64'(o_clear),  64'(ec));
        chk("done",   64'(o_done),   64'(ed));
        chk("ready",  64'(o_ready),  64'(er));

        i_valid = v; i_last = l; i_a_col = a; i_b_row = b;
        acc     = v && er;
        n.acc   = acc;
        n.last  = acc && l;
        n.first = acc && !in_matrix;
        n.a     = acc ? a : '0;
        n.b     = acc ? b : '0;
        hist.push_back(n);
        if (acc) in_matrix = !l;
        if (acc && l) last_cyc = cyc;

        @(posedge i_clock);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0);
    endtask

    // Assert the reset away from any clock edge. The outputs must clear at once.
    task automatic rst_pulse();
        i_valid = 1'b0; i_last = 1'b0;
        #2 i_reset = 1'b1;
        #1;
        chk("rst_a",     64'(o_a_full), 64'd0);
        chk("rst_b",     64'(o_b_full), 64'd0);
        chk("rst_valid", 64'(o_valid),  64'd0);
        chk("rst_clear", 64'(o_clear),  64'd0);
        chk("rst_done",  64'(o_done),   64'd0);
        chk("rst_ready", 64'(o_ready),  64'd1);
        #2 i_reset = 1'b0;
        model_reset();
        @(posedge i_clock);
        #1;
        cyc++;
    endtask

    initial begin
        i_reset = 1'b1; i_valid = 1'b0; i_last = 1'b0; i_a_col = '0; i_b_row = '0;
        #12 i_reset = 1'b0;
        model_reset();
        @(posedge i_clock);
        #1;

        // Reset state after power-up.
        idle(2);

        // Test 1: put data in flight, then apply an asynchronous reset mid-cycle.
        step(1'b1, 1'b0, mk(0, 8'h40), mk(0, 8'h80));
        step(1'b1, 1'b0, mk(1, 8'h40), mk(1, 8'h80));
        rst_pulse();
        idle(2);

        // Tests 2, 4 and 5: four beats, drain window, then a single-beat matrix.
        t0 = cyc;
        step(1'b1, 1'b0, mk(0, 0), mk(0, 8'hA0));
        chk("t2_clear_c1", 64'(o_clear), 64'd1);
        step(1'b1, 1'b0, mk(1, 0), mk(1, 8'hA0));
        step(1'b1, 1'b0, mk(2, 0), mk(2, 8'hA0));
        chk("t2_lane2_c3", 64'(ln(o_a_full, 2)), 64'h02);
        step(1'b1, 1'b1, mk(3, 0), mk(3, 8'hA0));
        chk("t2_lane2_c4", 64'(ln(o_a_full, 2)), 64'h12);
        chk("t4_ready_c4", 64'(o_ready), 64'd0);
        step(1'b1, 1'b0, 32'hDEADBEEF, 32'hCAFEF00D);
        step(1'b1, 1'b1, 32'h11111111, 32'h22222222);
        idle(1);
        chk("t2_lane3_c7", 64'(ln(o_a_full, 3)), 64'h33);
        chk("t2_done_c7",  64'(o_done), 64'd1);
        for (int i = 7; i < 12; i++) step(1'b1, (i % 2) == 1, 32'h5A5A5A5A, 32'hA5A5A5A5);
        chk("t4_ready_c12", 64'(o_ready), 64'd1);
        step(1'b1, 1'b1, mk(0, 8'h07), mk(0, 8'hC1));
        chk("t5_clear_c13", 64'(o_clear), 64'd1);
        chk("t5_b0_c13",    64'(ln(o_b_full, 0)), 64'hC1);
        idle(c_DRAIN + 1);

        // Test 3: bubble in cycle 2, so the beats arrive at 0, 1, 3 and 4.
        step(1'b1, 1'b0, mk(0, 1), mk(0, 8'h90));
        step(1'b1, 1'b0, mk(1, 1), mk(1, 8'h90));
        step(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        step(1'b1, 1'b0, mk(2, 1), mk(2, 8'h90));
        step(1'b1, 1'b1, mk(3, 1), mk(3, 8'h90));
        idle(1);
        chk("t3_lane3_c6", 64'(ln(o_a_full, 3)), 64'h00);
        chk("t3_valid_c6", 64'(o_valid), 64'd1);
        step(1'b0, 1'b0, '0, '0);
        chk("t3_lane3_c7", 64'(ln(o_a_full, 3)), 64'h24);
        idle(c_DRAIN + 2);

        // Test 6: reset in cycle 5 of a matrix kills o_done; next beat clears afresh.
        for (int k = 0; k < 4; k++) step(1'b1, k == 3, mk(k, 2), mk(k, 8'hB0));
        step(1'b0, 1'b0, '0, '0);
        rst_pulse();
        chk("t6_ready", 64'(o_ready), 64'd1);
        step(1'b1, 1'b1, mk(0, 8'h0C), mk(0, 8'hE0));
        chk("t6_clear", 64'(o_clear), 64'd1);
        idle(c_DRAIN + 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
